// File: rtl/ula_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package ula_pkg;

  typedef enum logic [2:0] {
    OpAddi = 3'b000,
    OpAdd  = 3'b001,
    OpSubi = 3'b010,
    OpBeq  = 3'b011,
    OpAnd  = 3'b100,
    OpSub  = 3'b101,
    OpMul  = 3'b110,
    OpLi   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StOcioso = 2'b00,
    StMult   = 2'b01,
    StSaida  = 2'b10
  } estado_e;

endpackage

// File: rtl/ula_mult_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, LARGURA cycles.
module ula_mult_seq #(
  parameter int unsigned LARGURA = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [LARGURA-1:0]     op_a_i,
  input  logic [LARGURA-1:0]     op_b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2*LARGURA-1:0]   product_o
);

  localparam int unsigned CntW = $clog2(LARGURA + 1);

  logic               busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] hi_q, hi_d;
  logic [LARGURA-1:0] lo_q, lo_d;
  logic [LARGURA:0]   soma;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    soma   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(LARGURA);
      a_d    = op_a_i;
      hi_d   = '0;
      lo_d   = op_b_i;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        // Add then shift the {carry, hi, lo} accumulator right by one.
        hi_d  = soma[LARGURA:1];
        lo_d  = {soma[0], lo_q[LARGURA-1:1]};
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q & (cnt_q == '0);
  assign product_o = {hi_q, lo_q};

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU with valid/ready handshake and registered result/flags.
// Define ULA_SEQ_MUL_EN to build the iterative multiplier; otherwise MUL reports Erro.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LARGURA-1:0] Dado1,
  input  logic [LARGURA-1:0] Dado2,
  input  logic [2:0]         ULAOp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LARGURA-1:0] Result,
  output logic [LARGURA-1:0] ResultHi,
  output logic               Zero,
  output logic               Carry,
  output logic               Overflow,
  output logic               Negativo,
  output logic               Erro
);

  localparam int unsigned Msb = LARGURA - 1;

  estado_e            state_q, state_d;
  logic [LARGURA-1:0] result_q, result_d;
  logic [LARGURA-1:0] result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               negativo_q, negativo_d;
  logic               erro_q, erro_d;

  op_e                op;
  logic               accept;
  logic               vai_mult;
  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   dif;
  logic [LARGURA-1:0] alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_erro;

  assign op       = op_e'(ULAOp);
  assign in_ready = (state_q == StOcioso);
  assign accept   = in_valid & in_ready;

`ifdef ULA_SEQ_MUL_EN
  logic                   mul_start;
  logic                   mul_busy;
  logic                   mul_done;
  logic [2*LARGURA-1:0]   mul_product;

  assign vai_mult  = (op == OpMul);
  assign mul_start = accept & vai_mult;

  ula_mult_seq #(
    .LARGURA (LARGURA)
  ) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .op_a_i    (Dado1),
    .op_b_i    (Dado2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`else
  assign vai_mult = 1'b0;
`endif

  // Single-cycle datapath; MUL lands here only when the multiplier is not built.
  always_comb begin
    soma      = {1'b0, Dado1} + {1'b0, Dado2};
    dif       = {1'b0, Dado1} - {1'b0, Dado2};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_erro  = 1'b0;
    unique case (op)
      OpAdd, OpAddi: begin
        alu_res   = soma[Msb:0];
        alu_carry = soma[LARGURA];
        alu_ovf   = (Dado1[Msb] == Dado2[Msb]) && (alu_res[Msb] != Dado1[Msb]);
      end
      OpSub, OpSubi, OpBeq: begin
        alu_res   = dif[Msb:0];
        alu_carry = dif[LARGURA];
        alu_ovf   = (Dado1[Msb] != Dado2[Msb]) && (alu_res[Msb] != Dado1[Msb]);
      end
      OpAnd:   alu_res  = Dado1 & Dado2;
      OpLi:    alu_res  = Dado2;
      OpMul:   alu_erro = 1'b1;
      default: alu_res  = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    negativo_d  = negativo_q;
    erro_d      = erro_q;
    unique case (state_q)
      StOcioso: begin
        if (accept) begin
          if (vai_mult) begin
            state_d = StMult;
          end else begin
            state_d     = StSaida;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (op == OpBeq) ? (Dado1 == Dado2) : (alu_res == '0);
            carry_d     = alu_carry;
            overflow_d  = alu_ovf;
            negativo_d  = alu_res[Msb];
            erro_d      = alu_erro;
          end
        end
      end
`ifdef ULA_SEQ_MUL_EN
      StMult: begin
        if (mul_busy && mul_done) begin
          state_d     = StSaida;
          result_d    = mul_product[Msb:0];
          result_hi_d = mul_product[2*LARGURA-1:LARGURA];
          zero_d      = (mul_product[Msb:0] == '0);
          carry_d     = 1'b0;
          overflow_d  = (mul_product[2*LARGURA-1:LARGURA] != '0);
          negativo_d  = mul_product[Msb];
          erro_d      = 1'b0;
        end
      end
`endif
      StSaida: begin
        if (out_ready) begin
          state_d = StOcioso;
        end
      end
      default: state_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOcioso;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      negativo_q  <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      negativo_q  <= negativo_d;
      erro_q      <= erro_d;
    end
  end

  assign out_valid = (state_q == StSaida);
  assign Result    = result_q;
  assign ResultHi  = result_hi_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign Overflow  = overflow_q;
  assign Negativo  = negativo_q;
  assign Erro      = erro_q;

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (LARGURA = 8): directed cases plus random ops vs. a model.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 8;

`ifdef ULA_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         o;
    logic         n;
    logic         e;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Dado1;
  logic [W-1:0] Dado2;
  logic [2:0]   ULAOp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic         Zero;
  logic         Carry;
  logic         Overflow;
  logic         Negativo;
  logic         Erro;

  int n_checks = 0;
  int n_errors = 0;

  ula_seq #(
    .LARGURA (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Dado1     (Dado1),
    .Dado2     (Dado2),
    .ULAOp     (ULAOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .ResultHi  (ResultHi),
    .Zero      (Zero),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Negativo  (Negativo),
    .Erro      (Erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input op_e op, input int a, input int b);
    exp_t r;
    int   full;
    int   s;
    int   lim;
    r   = '0;
    lim = 1 << (W - 1);
    case (op)
      OpAdd, OpAddi: begin
        full  = a + b;
        r.res = W'(full % (1 << W));
        r.c   = (full >= (1 << W));
        s     = to_signed(a) + to_signed(b);
        r.o   = (s >= lim) || (s < -lim);
      end
      OpSub, OpSubi, OpBeq: begin
        full  = a - b;
        r.res = W'((full + (1 << W)) % (1 << W));
        r.c   = (a < b);
        s     = to_signed(a) - to_signed(b);
        r.o   = (s >= lim) || (s < -lim);
      end
      OpAnd: r.res = W'(a & b);
      OpLi:  r.res = W'(b);
      default: begin
        if (MulEn) begin
          full  = a * b;
          r.res = W'(full % (1 << W));
          r.hi  = W'(full / (1 << W));
          r.o   = (r.hi != 0);
        end else begin
          r.e = 1'b1;
        end
      end
    endcase
    r.z = (op == OpBeq) ? (a == b) : (r.res == 0);
    r.n = r.res[W-1];
    return r;
  endfunction

  task automatic check_outs(input string tag, input exp_t x);
    check({tag, ".res"}, 32'(Result), 32'(x.res));
    check({tag, ".hi"}, 32'(ResultHi), 32'(x.hi));
    check({tag, ".flags"}, {27'd0, Zero, Carry, Overflow, Negativo, Erro},
          {27'd0, x.z, x.c, x.o, x.n, x.e});
  endtask

  // Issue one op, measure latency, optionally stall the consumer for `hold` cycles.
  task automatic run_op(input string tag, input op_e op, input int a, input int b,
                        input int hold);
    exp_t x;
    int   lat;
    int   want_lat;
    x        = model(op, a, b);
    want_lat = (op == OpMul && MulEn) ? W + 1 : 1;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    ULAOp     = op;
    Dado1     = W'(a);
    Dado2     = W'(b);
    @(negedge clk);
    in_valid = 1'b0;
    Dado1    = W'($urandom);
    Dado2    = W'($urandom);
    ULAOp    = 3'($urandom);
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(want_lat));
    check_outs(tag, x);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      Dado1    = W'($urandom);
      Dado2    = W'($urandom);
      ULAOp    = 3'($urandom);
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check_outs({tag, ".hold"}, x);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drained"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Dado1     = '0;
    Dado2     = '0;
    ULAOp     = '0;
    #12;
    check("rst.ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    check_outs("rst", '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ff_01", OpAdd, 'hFF, 'h01, 0);
    run_op("sub_80_01", OpSub, 'h80, 'h01, 0);
    run_op("beq_05_05", OpBeq, 'h05, 'h05, 0);
    run_op("beq_05_06", OpBeq, 'h05, 'h06, 0);
    run_op("mul_0d_14", OpMul, 'h0D, 'h14, 0);
    run_op("mul_0f_11", OpMul, 'h0F, 'h11, 0);
    run_op("mul_03_04", OpMul, 'h03, 'h04, 0);
    run_op("li_hold3", OpLi, 'h3C, 'hA5, 3);
    run_op("mul_hold3", OpMul, 'hFF, 'hFF, 3);

    // Reset during a MUL: the operation must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    ULAOp    = OpMul;
    Dado1    = 'h0D;
    Dado2    = 'h14;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    check_outs("midrst", '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst.no_valid", 32'(seen), 32'd0);
    run_op("add_02_03", OpAdd, 'h02, 'h03, 0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", op_e'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter LARGURA, default 8, operand/result width in bits (min 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 Dado1  input  LARGURA  first operand.
REQ-007 Dado2  input  LARGURA  second operand / immediate.
REQ-008 ULAOp  input  3  opcode: 000 ADDI, 001 ADD, 010 SUBI, 011 BEQ, 100 AND, 101 SUB, 110 MUL, 111 LI.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 Result  output  LARGURA  result, low half for MUL.
REQ-012 ResultHi  output  LARGURA  high half of MUL product; 0 for other ops.
REQ-013 Zero, Carry, Overflow, Negativo  output  1 each  registered flags.
REQ-014 Erro  output  1  unsupported opcode in this build.

Function
REQ-015 FSM states OCIOSO, MULT, SAIDA; in_ready = 1 only in OCIOSO.
REQ-016 Accept = in_valid & in_ready; operands and opcode are captured at accept; inputs are ignored at all other times.
REQ-017 Non-MUL ops: OCIOSO -> SAIDA on accept; out_valid rises the cycle after accept (latency 1).
REQ-018 MUL: OCIOSO -> MULT on accept; shift-add, one bit per cycle, LARGURA cycles; MULT -> SAIDA; out_valid rises exactly LARGURA+1 cycles after accept.
REQ-019 SAIDA -> OCIOSO when out_ready = 1; Result, ResultHi, flags and out_valid are held stable while out_ready = 0.
REQ-020 ADD/ADDI: Result = Dado1+Dado2 mod 2^LARGURA; Carry = carry-out; Overflow = signed overflow.
REQ-021 SUB/SUBI: Result = Dado1-Dado2; Carry = 1 when borrow (Dado1 < Dado2 unsigned); Overflow = signed overflow.
REQ-022 BEQ: Result = Dado1-Dado2; Zero = (Dado1 == Dado2); Carry/Overflow as for SUB.
REQ-023 AND: bitwise; LI: Result = Dado2; Carry = Overflow = 0 for both.
REQ-024 MUL: unsigned full product {ResultHi,Result}; Overflow = (ResultHi != 0); Carry = 0.
REQ-025 Zero = (Result == 0) for all ops except BEQ; Negativo = Result MSB for all ops.
REQ-026 Erro = 0 for all ops except REQ-034.

Reset
REQ-027 rst_n low asynchronously forces state OCIOSO; in_ready = 1 in OCIOSO; out_valid, Result, ResultHi, all flags and Erro = 0.
REQ-028 Reset during MULT or SAIDA discards the operation; no out_valid is produced for it.
REQ-029 Release: first accept is possible on the first rising edge with rst_n high.

Configuration
REQ-030 Macro ULA_SEQ_MUL_EN defined: MUL implemented per REQ-018/024.
REQ-031 Macro absent: no multiplier logic or MULT state is present.
REQ-032 Macro absent: MUL takes the 1-cycle path.
REQ-033 Macro absent, MUL result values: Result = ResultHi = 0, Zero = 1.
REQ-034 Macro absent, MUL error flag: Erro = 1.

Structure
REQ-035 Package ula_pkg holds the opcode enum (3 bits) and the FSM state enum; ula_seq and the testbench import it.
REQ-036 Sub-module ula_mult_seq holds the iterative multiplier (start, busy, done, product) and is instantiated only under ULA_SEQ_MUL_EN.

Verification (LARGURA = 8)
REQ-037 ADD FF+01 -> Result 00, Zero 1, Carry 1, Overflow 0; out_valid 1 cycle after accept.
REQ-038 SUB 80-01 -> Result 7F, Overflow 1, Negativo 0; BEQ 05,05 -> Zero 1.
REQ-039 MUL 0D*14 -> Result 04, ResultHi 01, Overflow 1, out_valid exactly 9 cycles after accept; MUL 0F*11 -> FF, ResultHi 00.
REQ-040 out_ready held 0 for 3 cycles after out_valid -> outputs unchanged, in_ready 0; a new in_valid in that window is not accepted.
REQ-041 rst_n pulsed low at cycle 4 of a MUL -> out_valid 0, in_ready 1 immediately; next ADD 02+03 -> Result 05.
REQ-042 Build without ULA_SEQ_MUL_EN, MUL 03*04 -> Result 00, Erro 1, latency 1.
